// File: rtl/os_pkg.sv
// Shared types and helpers for the output-stationary result drain.
// OS_RESULT_DRAIN_SAT_EN selects saturating narrowing; the default build wraps.
package os_pkg;

    typedef enum logic {
        IDLE,
        DRAIN
    } drain_state_e;

    localparam int DEF_ARRAY_SIZE = 4;
    localparam int ROW_W = (DEF_ARRAY_SIZE > 1) ? $clog2(DEF_ARRAY_SIZE) : 1;

    function automatic int row_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Arithmetic shift on a sign-extended value; the caller keeps the low out_w bits.
    function automatic logic signed [63:0] narrow(input logic signed [63:0] acc,
                                                  input int shift,
                                                  input int out_w);
        logic signed [63:0] s;
`ifdef OS_RESULT_DRAIN_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
`endif
        s = acc >>> shift;
`ifdef OS_RESULT_DRAIN_SAT_EN
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (s > hi) begin
            s = hi;
        end else if (s < lo) begin
            s = lo;
        end
`else
        if (out_w < 1) begin
            s = '0;
        end
`endif
        return s;
    endfunction

endpackage

// File: rtl/os_result_narrow.sv
// Combinational shift-and-narrow of one accumulator element.
// Saturation vs. wrap is chosen by OS_RESULT_DRAIN_SAT_EN inside os_pkg::narrow.
module os_result_narrow
    import os_pkg::*;
#(
    parameter int ACC_WIDTH = 24,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 0
) (
    input  logic [ACC_WIDTH-1:0] acc,
    output logic [OUT_WIDTH-1:0] res
);

    assign res = OUT_WIDTH'(narrow(64'(signed'(acc)), SHIFT, OUT_WIDTH));

endmodule

// File: rtl/os_result_drain.sv
// Snapshots the PE accumulator matrix and streams it out one row per beat.
// Build with OS_RESULT_DRAIN_SAT_EN for saturating narrowing (default wraps).
module os_result_drain
    import os_pkg::*;
#(
    parameter int ARRAY_SIZE = 4,
    parameter int ACC_WIDTH  = 24,
    parameter int OUT_WIDTH  = 8,
    parameter int SHIFT      = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ACC_WIDTH-1:0]             acc_result [ARRAY_SIZE][ARRAY_SIZE],
    input  logic                             capture_valid,
    output logic                             capture_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ARRAY_SIZE*OUT_WIDTH-1:0]  out_data,
    output logic [row_width(ARRAY_SIZE)-1:0] out_row,
    output logic                             out_last,
    output logic [CNT_WIDTH-1:0]             tile_cnt
);

    localparam int RW = row_width(ARRAY_SIZE);
    localparam logic [RW-1:0] LAST_ROW = RW'(ARRAY_SIZE - 1);

    drain_state_e state;
    drain_state_e state_next;
    logic [RW-1:0] row;
    logic [ACC_WIDTH-1:0] snap [ARRAY_SIZE][ARRAY_SIZE];
    logic [OUT_WIDTH-1:0] row_narrow [ARRAY_SIZE];
    logic fire;
    logic last_fire;
    logic take;

    assign fire          = (state == DRAIN) && out_ready;
    assign last_fire     = fire && (row == LAST_ROW);
    // Last-beat handshake frees the snapshot, so a waiting tile can be taken with no bubble.
    assign capture_ready = (state == IDLE) || last_fire;
    assign take          = capture_valid && capture_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (take) state_next = DRAIN;
            DRAIN:   if (last_fire) state_next = take ? DRAIN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            row      <= '0;
            tile_cnt <= '0;
        end else begin
            state <= state_next;
            if (take) begin
                row <= '0;
            end else if (fire) begin
                row <= (row == LAST_ROW) ? '0 : row + 1'b1;
            end
            if (last_fire) begin
                tile_cnt <= tile_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            snap <= acc_result;
        end
    end

    for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_narrow
        os_result_narrow #(
            .ACC_WIDTH (ACC_WIDTH),
            .OUT_WIDTH (OUT_WIDTH),
            .SHIFT     (SHIFT)
        ) u_narrow (
            .acc (snap[row][j]),
            .res (row_narrow[j])
        );
    end

    // Data is forced to zero while idle so the stale, unreset snapshot never leaks out.
    always_comb begin
        out_data = '0;
        if (state == DRAIN) begin
            for (int j = 0; j < ARRAY_SIZE; j++) begin
                out_data[j*OUT_WIDTH +: OUT_WIDTH] = row_narrow[j];
            end
        end
    end

    assign out_valid = (state == DRAIN);
    assign out_row   = row;
    assign out_last  = out_valid && (row == LAST_ROW);

endmodule

// File: tb/tb_os_result_drain.sv
// Bench for os_result_drain: two instances (SHIFT=0/CNT_WIDTH=16 and SHIFT=4/CNT_WIDTH=2)
// share stimulus and are checked every cycle against a tile-level reference model.
module tb_os_result_drain;
    import os_pkg::*;

    localparam int N  = 4;
    localparam int AW = 24;
    localparam int OW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] acc_result [N][N];
    logic          capture_valid;
    logic          out_ready;

    logic              cap_ready_a, out_valid_a, out_last_a;
    logic [N*OW-1:0]   out_data_a;
    logic [ROW_W-1:0]  out_row_a;
    logic [15:0]       tile_cnt_a;
    logic              cap_ready_b, out_valid_b, out_last_b;
    logic [N*OW-1:0]   out_data_b;
    logic [ROW_W-1:0]  out_row_b;
    logic [1:0]        tile_cnt_b;

    os_result_drain #(.ARRAY_SIZE(N), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(0), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .acc_result(acc_result), .capture_valid(capture_valid),
        .capture_ready(cap_ready_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_row(out_row_a), .out_last(out_last_a), .tile_cnt(tile_cnt_a)
    );

    os_result_drain #(.ARRAY_SIZE(N), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(4), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst), .acc_result(acc_result), .capture_valid(capture_valid),
        .capture_ready(cap_ready_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_row(out_row_b), .out_last(out_last_b), .tile_cnt(tile_cnt_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the tile being drained, which row is on the bus, tiles completed.
    logic [AW-1:0] m_tile [N][N];
    bit            m_busy;
    int            m_row;
    int            m_tiles;
    bit            m_took;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] ref_elem(input logic [AW-1:0] v, input int sh);
        longint s;
        s = longint'(signed'(v));
        s = s >>> sh;
`ifdef OS_RESULT_DRAIN_SAT_EN
        if (s > 127) s = 127;
        else if (s < -128) s = -128;
`endif
        return s[OW-1:0];
    endfunction

    function automatic logic [N*OW-1:0] ref_row(input int r, input int sh);
        logic [N*OW-1:0] res;
        res = '0;
        for (int j = 0; j < N; j++) res[j*OW +: OW] = ref_elem(m_tile[r][j], sh);
        return res;
    endfunction

    task automatic checkAll();
        bit          e_rdy;
        logic [31:0] e_a, e_b;
        e_rdy = !m_busy || ((m_row == N-1) && out_ready);
        e_a   = m_busy ? ref_row(m_row, 0) : '0;
        e_b   = m_busy ? ref_row(m_row, 4) : '0;
        checkOutput("a_capture_ready", 64'(cap_ready_a), 64'(e_rdy));
        checkOutput("a_out_valid",     64'(out_valid_a), 64'(m_busy));
        checkOutput("a_out_row",       64'(out_row_a),   64'(m_busy ? m_row : 0));
        checkOutput("a_out_last",      64'(out_last_a),  64'(m_busy && m_row == N-1));
        checkOutput("a_out_data",      64'(out_data_a),  64'(e_a));
        checkOutput("a_tile_cnt",      64'(tile_cnt_a),  64'(m_tiles % 65536));
        checkOutput("b_capture_ready", 64'(cap_ready_b), 64'(e_rdy));
        checkOutput("b_out_valid",     64'(out_valid_b), 64'(m_busy));
        checkOutput("b_out_row",       64'(out_row_b),   64'(m_busy ? m_row : 0));
        checkOutput("b_out_last",      64'(out_last_b),  64'(m_busy && m_row == N-1));
        checkOutput("b_out_data",      64'(out_data_b),  64'(e_b));
        checkOutput("b_tile_cnt",      64'(tile_cnt_b),  64'(m_tiles % 4));
    endtask

    task automatic applyStimulus(input bit r, input bit cv, input bit ordy);
        rst           = r;
        capture_valid = cv;
        out_ready     = ordy;
        #1;
        checkAll();
    endtask

    task automatic tick();
        bit rdy;
        @(posedge clk);
        m_took = 0;
        rdy = !m_busy || ((m_row == N-1) && out_ready);
        if (rst) begin
            m_busy  = 0;
            m_row   = 0;
            m_tiles = 0;
        end else begin
            if (m_busy && out_ready) begin
                if (m_row == N-1) begin
                    m_tiles++;
                    m_busy = 0;
                    m_row  = 0;
                end else begin
                    m_row++;
                end
            end
            if (capture_valid && rdy) begin
                m_tile = acc_result;
                m_busy = 1;
                m_row  = 0;
                m_took = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic loadRandom();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                case ($urandom_range(0, 5))
                    0:       acc_result[i][j] = 24'h7FFFFF;
                    1:       acc_result[i][j] = 24'h800000;
                    default: acc_result[i][j] = AW'($urandom);
                endcase
    endtask

    task automatic drainTile();
        applyStimulus(0, 1, 1);
        tick();
        for (int r = 0; r < N; r++) begin
            applyStimulus(0, 0, 1);
            tick();
        end
    endtask

    bit pending;
    int base;

    initial begin
        rst = 1; capture_valid = 0; out_ready = 0;
        m_busy = 0; m_row = 0; m_tiles = 0; m_took = 0;
        loadRandom();
        @(posedge clk); @(posedge clk); @(negedge clk);
        applyStimulus(0, 0, 0);
        tick();

        // Basic drain with SHIFT=0 on dut_a.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) acc_result[i][j] = AW'(i*4 + j);
        applyStimulus(0, 1, 1);
        tick();
        for (int k = 0; k < N; k++) begin
            applyStimulus(0, 0, 1);
            if (k == 2) checkOutput("basic_row2", 64'(out_data_a), 64'h0B0A0908);
            if (k == 3) checkOutput("basic_last", 64'(out_last_a), 64'd1);
            tick();
        end
        applyStimulus(0, 0, 0);
        checkOutput("basic_tile_cnt", 64'(tile_cnt_a), 64'd1);

        // Shift/narrow with SHIFT=4 on dut_b, then stall on row 1.
        loadRandom();
        acc_result[0][0] = 24'h000123;
        acc_result[0][1] = 24'h012345;
        acc_result[0][2] = 24'hFFF000;
        acc_result[0][3] = 24'h000000;
        applyStimulus(0, 1, 1);
        tick();
        applyStimulus(0, 0, 0);
`ifdef OS_RESULT_DRAIN_SAT_EN
        checkOutput("shift_row0", 64'(out_data_b), 64'h00807F12);
`else
        checkOutput("shift_row0", 64'(out_data_b), 64'h00003412);
`endif
        tick();
        applyStimulus(0, 0, 1);
        tick();
        for (int k = 0; k < 3; k++) begin
            loadRandom();
            applyStimulus(0, 1, 0);
            checkOutput("stall_row", 64'(out_row_a), 64'd1);
            checkOutput("stall_cap_ready", 64'(cap_ready_a), 64'd0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 1);
            tick();
        end

        // Back-to-back tiles: B offered on A's last beat.
        base = m_tiles;
        loadRandom();
        applyStimulus(0, 1, 1);
        tick();
        for (int k = 0; k < N-1; k++) begin
            applyStimulus(0, 0, 1);
            tick();
        end
        loadRandom();
        applyStimulus(0, 1, 1);
        checkOutput("b2b_cap_ready", 64'(cap_ready_a), 64'd1);
        tick();
        for (int k = 0; k < N; k++) begin
            applyStimulus(0, 0, 1);
            if (k == 0) checkOutput("b2b_row0_valid", 64'(out_valid_a), 64'd1);
            tick();
        end
        applyStimulus(0, 0, 0);
        checkOutput("b2b_tile_cnt", 64'(tile_cnt_a), 64'(base + 2));

        // Reset mid-drain.
        loadRandom();
        drainTile();
        applyStimulus(0, 1, 1);
        tick();
        applyStimulus(0, 0, 1);
        tick();
        applyStimulus(1, 0, 1);
        tick();
        applyStimulus(1, 0, 1);
        tick();
        applyStimulus(0, 0, 0);
        checkOutput("rst_cap_ready", 64'(cap_ready_a), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid_a), 64'd0);
        checkOutput("rst_tile_cnt",  64'(tile_cnt_a),  64'd0);

        // Counter wrap on dut_b (CNT_WIDTH=2).
        for (int t = 0; t < 5; t++) begin
            loadRandom();
            drainTile();
        end
        applyStimulus(0, 0, 0);
        checkOutput("wrap_tile_cnt_b", 64'(tile_cnt_b), 64'd1);
        checkOutput("wrap_tile_cnt_a", 64'(tile_cnt_a), 64'd5);

        // Randomized traffic with a producer that holds each tile until taken.
        pending = 0;
        for (int c = 0; c < 600; c++) begin
            bit r;
            if (!pending && $urandom_range(0, 2) == 0) begin
                loadRandom();
                pending = 1;
            end
            r = ($urandom_range(0, 99) == 0);
            applyStimulus(r, pending, $urandom_range(0, 3) != 0);
            tick();
            if (m_took) pending = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
